// File: rtl/chacha20_block_seq.sv
// ChaCha20 block engine: serial load, one quarter-round per cycle, feed-forward add,
// serial result stream. Includes the combinational chacha20_qr it drives.

module chacha20_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a2,
  output logic [31:0] b2,
  output logic [31:0] c2,
  output logic [31:0] d2
);
  logic [31:0] a_1, b_1, c_1, d_1;
  logic [31:0] dx_1, bx_1, dx_2, bx_2;

  // a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; then the same with rotations 8 and 7
  assign a_1  = a + b;
  assign dx_1 = d ^ a_1;
  assign d_1  = {dx_1[15:0], dx_1[31:16]};
  assign c_1  = c + d_1;
  assign bx_1 = b ^ c_1;
  assign b_1  = {bx_1[19:0], bx_1[31:20]};
  assign a2   = a_1 + b_1;
  assign dx_2 = d_1 ^ a2;
  assign d2   = {dx_2[23:0], dx_2[31:24]};
  assign c2   = c_1 + d2;
  assign bx_2 = b_1 ^ c2;
  assign b2   = {bx_2[24:0], bx_2[31:25]};
endmodule

// state | meaning
// LOAD  | accepting input words 0..15 into x and s
// RUN   | one quarter-round per cycle, columns on even rcnt, diagonals on odd
// OUT   | streaming x[i]+s[i], word 0 first
module chacha20_block_seq #(
  parameter int unsigned ROUNDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);
  localparam int RCW = 8;

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  state_t          state;
  logic [31:0]     x [16];
  logic [31:0]     s [16];
  logic [3:0]      widx;
  logic [RCW-1:0]  rcnt;
  logic [1:0]      q;

  logic [1:0]  qb, qc, qd;
  logic [3:0]  ia, ib, ic, id;
  logic [31:0] qa2, qb2, qc2, qd2;

  // diagonal rounds rotate the lane within each row of four
  assign qb = rcnt[0] ? q + 2'd1 : q;
  assign qc = rcnt[0] ? q + 2'd2 : q;
  assign qd = rcnt[0] ? q + 2'd3 : q;
  assign ia = {2'b00, q};
  assign ib = {2'b01, qb};
  assign ic = {2'b10, qc};
  assign id = {2'b11, qd};

  chacha20_qr u_qr (
    .a  (x[ia]),
    .b  (x[ib]),
    .c  (x[ic]),
    .d  (x[id]),
    .a2 (qa2),
    .b2 (qb2),
    .c2 (qc2),
    .d2 (qd2)
  );

  assign out_data = out_valid ? (x[widx] + s[widx]) : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      widx      <= '0;
      rcnt      <= '0;
      q         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            x[widx] <= in_data;
            s[widx] <= in_data;
            if (widx == 4'd15) begin
              widx     <= '0;
              rcnt     <= '0;
              q        <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              if (ROUNDS == 0) begin
                state     <= OUT;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
              end else begin
                state <= RUN;
              end
            end else begin
              widx <= widx + 4'd1;
            end
          end
        end
        RUN: begin
          x[ia] <= qa2;
          x[ib] <= qb2;
          x[ic] <= qc2;
          x[id] <= qd2;
          q     <= q + 2'd1;
          if (q == 2'd3) begin
            if (rcnt == RCW'(ROUNDS - 1)) begin
              state     <= OUT;
              rcnt      <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (widx == 4'd15) begin
              state     <= LOAD;
              widx      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              widx     <= widx + 4'd1;
              out_last <= (widx == 4'd14);
            end
          end
        end
        default: begin
          state     <= LOAD;
          widx      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chacha20_block_seq.sv
// Directed bench for chacha20_block_seq: RFC 7539 block, stalls, latency, reset abort,
// back-to-back blocks, and a ROUNDS=0 instance for the pure feed-forward path.
module tb_chacha20_block_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, sel;
  logic [31:0] in_data;

  logic        a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [31:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [31:0] b_out_data;

  logic        o_in_ready, o_valid, o_last, o_busy;
  logic [31:0] o_data;

  chacha20_block_seq #(.ROUNDS(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & ~sel),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready & ~sel),
    .out_data  (a_out_data),
    .out_last  (a_out_last),
    .busy      (a_busy)
  );

  chacha20_block_seq #(.ROUNDS(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & sel),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready & sel),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  assign o_in_ready = sel ? b_in_ready  : a_in_ready;
  assign o_valid    = sel ? b_out_valid : a_out_valid;
  assign o_last     = sel ? b_out_last  : a_out_last;
  assign o_busy     = sel ? b_busy      : a_busy;
  assign o_data     = sel ? b_out_data  : a_out_data;

  localparam logic [31:0] RFC_IN [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [31:0] RFC_OUT [16] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  logic [31:0] vin  [16];
  logic [31:0] vexp [16];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic load_vin();
    for (int i = 0; i < 16; i++) begin
      chk("in_ready_load", {31'd0, o_in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = vin[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
  endtask

  // latency counted in cycles from the last input handshake cycle
  task automatic wait_lat(input int exp_lat);
    int cnt;
    int viol;
    cnt  = 1;
    viol = 0;
    while (!o_valid && cnt < 300) begin
      if (o_in_ready || !o_busy) viol++;
      in_valid = cnt[1];
      in_data  = 32'hdeadbeef;
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    chk("latency", cnt, exp_lat);
    chk("run_ctrl", viol, 0);
  endtask

  task automatic read_blk(input bit stall);
    int i;
    int guard;
    i     = 0;
    guard = 0;
    while (i < 16 && guard < 500) begin
      chk($sformatf("word%0d", i), o_data, vexp[i]);
      chk($sformatf("last%0d", i), {31'd0, o_last}, {31'd0, (i == 15)});
      chk("out_ctrl", {30'd0, o_valid, o_in_ready}, 32'd2);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      guard++;
      if (out_ready) i++;
    end
    out_ready = 1'b0;
    chk("read_done", i, 16);
    chk("post_out", {29'd0, o_in_ready, o_valid, o_busy}, 32'd4);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 32'd0;
    sel       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_a", {28'd0, o_in_ready, o_valid, o_last, o_busy}, 32'h8);
    chk("rst_data_a", o_data, 32'd0);
    sel = 1'b1;
    #1;
    chk("rst_ctrl_b", {28'd0, o_in_ready, o_valid, o_last, o_busy}, 32'h8);
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vin  = RFC_IN;
    vexp = RFC_OUT;
    load_vin();
    wait_lat(81);
    read_blk(1'b0);

    load_vin();
    wait_lat(81);
    read_blk(1'b1);

    load_vin();
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctrl", {29'd0, o_in_ready, o_valid, o_busy}, 32'h4);
    @(negedge clk);
    reset = 1'b0;
    load_vin();
    wait_lat(81);
    read_blk(1'b0);

    // back-to-back: reload immediately after the final output handshake
    load_vin();
    wait_lat(81);
    read_blk(1'b0);

    sel = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      vin[i]  = 32'h80000000 + 32'(i);
      vexp[i] = 32'(2 * i);
    end
    load_vin();
    wait_lat(1);
    read_blk(1'b0);
    for (int i = 0; i < 16; i++) begin
      vin[i]  = 32'hffffffff - 32'(i);
      vexp[i] = 32'hfffffffe - 32'(2 * i);
    end
    load_vin();
    wait_lat(1);
    read_blk(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
